estagio_busca: RTL

- Instruction-fetch stage of the 8-bit processor, directly upstream of the control unit (UnidadeControle).
- Holds the PC and fetches 8-bit instructions from instruction memory over a req/ready handshake.
- Latches each fetched instruction and presents its Opcode/Funct fields to the control unit.
- Advances the PC (sequential, jump or branch) only when the control unit's PCWrite is accepted.

---
 rtl/estagio_busca_if.sv | 29 ++
 rtl/estagio_busca.sv | 118 +++++++++++
 2 files changed

// File: rtl/estagio_busca_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   mem_req   : fetch request, held until the word is returned
//   mem_addr  : fetch address, stable while mem_req=1
//   mem_ready : memory presents a valid mem_data this cycle
//   mem_data  : instruction word
// master = fetch stage, slave = instruction memory.
interface estagio_busca_if #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 8
);
    logic                   mem_req;
    logic [PC_WIDTH-1:0]    mem_addr;
    logic                   mem_ready;
    logic [INSTR_WIDTH-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_data
    );
endinterface

// File: rtl/estagio_busca.sv
// Instruction-fetch stage of the 8-bit processor, upstream of the control unit.
// Holds the PC, fetches one instruction at a time over a req/ready bus, latches
// it and presents Opcode/Funct to the control unit. The PC only advances when
// the control unit's PCWrite is accepted while no hazard stall is active.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   mem               : instruction-memory bus (master side)
//   stall             : hazard hold, blocks PC advance
//   pc_write          : PCWrite from the control unit
//   jump/jump_target  : absolute jump taken on the advancing edge
//   branch_taken/
//   branch_offset     : relative branch from pc+1 taken on the advancing edge
//   instr_valid/instr : latched instruction and its valid flag
//   opcode/funct      : instr[7:6] / instr[2:0]
//   pc, pc_plus1      : address of the latched instruction and its successor
//   fetch_count       : number of issued instructions, wraps at 8 bits
module estagio_busca #(
    parameter int unsigned         PC_WIDTH    = 8,
    parameter int unsigned         INSTR_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    estagio_busca_if.master        mem,
    input  logic                   stall,
    input  logic                   pc_write,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    jump_target,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_offset,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [1:0]             opcode,
    output logic [2:0]             funct,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus1,
    output logic [7:0]             fetch_count
);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    typedef enum logic [1:0] {
        FETCH,
        WAIT_MEM,
        ISSUE
    } state_t;

    state_t                 state, state_next;
    logic                   req_next;
    logic [PC_WIDTH-1:0]    addr_next;
    logic [INSTR_WIDTH-1:0] instr_next;
    logic                   valid_next;
    logic [PC_WIDTH-1:0]    pc_next;
    logic [PC_WIDTH-1:0]    target;
    logic [7:0]             count_next;

    assign pc_plus1 = pc + PC_ONE;
    assign opcode   = instr[7:6];
    assign funct    = instr[2:0];

    // Jump has priority over branch; sums wrap modulo 2^PC_WIDTH.
    assign target = jump         ? jump_target
                  : branch_taken ? pc_plus1 + branch_offset
                  :                pc_plus1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            instr        <= '0;
            instr_valid  <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            mem.mem_req  <= req_next;
            mem.mem_addr <= addr_next;
            instr        <= instr_next;
            instr_valid  <= valid_next;
            fetch_count  <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        req_next   = mem.mem_req;
        addr_next  = mem.mem_addr;
        instr_next = instr;
        valid_next = instr_valid;
        pc_next    = pc;
        count_next = fetch_count;
        case (state)
            FETCH: begin
                req_next   = 1'b1;
                addr_next  = pc;
                state_next = WAIT_MEM;
            end
            WAIT_MEM: begin
                // mem_ready is only meaningful here, where mem_req is high.
                if (mem.mem_ready) begin
                    instr_next = mem.mem_data;
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (pc_write && !stall) begin
                    pc_next    = target;
                    valid_next = 1'b0;
                    count_next = fetch_count + 8'd1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end
endmodule
